// File: rtl/task_stream_packet_buffer.sv
// task_stream_packet_buffer: store-and-forward packet FIFO; define TSB_DROP_OVERSIZE_EN to drop oversize packets instead of truncating them
module task_stream_packet_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tdata_valid,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic              i_tdata_last,
  output logic              o_tready,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_last,
  input  logic              i_data_ready,
  output logic              o_busy,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef enum logic [1:0] {s_IDLE, s_LOAD, s_DISCARD, s_SEND} state_t;
  state_t r_state, w_next_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic r_tready, r_overflow;
  logic w_accept, w_xfer, w_wr, w_end, w_flush;
  assign w_accept     = i_tdata_valid && r_tready;
  assign w_wr         = (r_state == s_LOAD) && w_accept;
  assign w_end        = (r_state == s_DISCARD) && w_accept && i_tdata_last;
  assign o_tready     = r_tready;
  assign o_overflow   = r_overflow;
  assign o_count      = r_count;
  assign o_empty      = r_count == '0;
  assign o_busy       = r_state != s_IDLE;
  assign o_data       = r_mem[r_rd_ptr];
  assign o_data_valid = (r_state == s_SEND) && !o_empty;
  assign o_data_last  = o_data_valid && (r_count == CNT_W'(1));
  assign w_xfer       = o_data_valid && i_data_ready;
`ifdef TSB_DROP_OVERSIZE_EN
  assign w_flush = w_end;
`else
  assign w_flush = 1'b0;
`endif
  // next-state: IDLE bubble, load until last or full, discard tail, send
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      s_IDLE:    w_next_state = s_LOAD;
      s_LOAD:    w_next_state = !w_accept ? s_LOAD : i_tdata_last ? s_SEND :
                                (r_count == CNT_W'(DEPTH - 1)) ? s_DISCARD : s_LOAD;
`ifdef TSB_DROP_OVERSIZE_EN
      s_DISCARD: w_next_state = w_end ? s_IDLE : s_DISCARD;
`else
      s_DISCARD: w_next_state = w_end ? s_SEND : s_DISCARD;
`endif
      s_SEND:    w_next_state = (w_xfer && o_data_last) ? s_IDLE : s_SEND;
      default:   w_next_state = s_IDLE;
    endcase
  end
  // state, registered ready/overflow, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= s_IDLE;
      r_tready   <= 1'b0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next_state;
      r_tready   <= (w_next_state == s_LOAD) || (w_next_state == s_DISCARD);
      r_overflow <= w_end;
      r_wr_ptr   <= w_flush ? '0 : w_wr ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
      r_rd_ptr   <= w_flush ? '0 : w_xfer ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
      r_count    <= w_flush ? '0 : w_wr ? r_count + CNT_W'(1) : w_xfer ? r_count - CNT_W'(1) : r_count;
    end
  end
  // storage array, written only while loading
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_tdata;
  end
endmodule

// File: tb/tb_task_stream_packet_buffer.sv
// tb_task_stream_packet_buffer: scoreboard bench with randomized packets against a packet-level model
module tb_task_stream_packet_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef TSB_DROP_OVERSIZE_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_tdata_valid = 1'b0, i_tdata_last = 1'b0, i_data_ready = 1'b1;
  logic [DATA_W-1:0] i_tdata = '0;
  logic o_tready, o_data_valid, o_data_last, o_busy, o_empty, o_overflow;
  logic [DATA_W-1:0] o_data;
  logic [CNT_W-1:0] o_count;
  int errors = 0, checks = 0;
  int ready_mode = 0, ovf_seen = 0, ovf_exp = 0, max_cnt = 0;
  logic [DATA_W-1:0] exp_d[$];
  logic exp_l[$];
  logic [DATA_W-1:0] pkt[$];
  logic held = 1'b0, prev_ovf = 1'b0;
  logic [DATA_W-1:0] held_d = '0;

  task_stream_packet_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tdata_valid(i_tdata_valid), .i_tdata(i_tdata),
    .i_tdata_last(i_tdata_last), .o_tready(o_tready), .o_data_valid(o_data_valid), .o_data(o_data),
    .o_data_last(o_data_last), .i_data_ready(i_data_ready), .o_busy(o_busy), .o_empty(o_empty),
    .o_count(o_count), .o_overflow(o_overflow));

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  always @(posedge i_clk) begin
    #1;
    i_data_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ~i_data_ready : 1'($urandom_range(0, 1));
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_data_valid) begin
        chk("tready_low_in_send", 32'(o_tready), 0);
        if (held) chk("stable_data", 32'(o_data), 32'(held_d));
        if (!i_data_ready) begin
          held = 1'b1;
          held_d = o_data;
        end else begin
          held = 1'b0;
          if (exp_d.size() == 0) fail("unexpected_word");
          else begin
            chk("data", 32'(o_data), 32'(exp_d.pop_front()));
            chk("last", 32'(o_data_last), 32'(exp_l.pop_front()));
          end
        end
      end else begin
        if (held) fail("valid_dropped_under_backpressure");
        held = 1'b0;
      end
      if (o_overflow) begin
        if (prev_ovf) fail("overflow_pulse_width");
        ovf_seen++;
      end
      prev_ovf = o_overflow;
      if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
    end else begin
      held = 1'b0;
      prev_ovf = 1'b0;
    end
  end

  task automatic fill(input int len);
    pkt.delete();
    for (int k = 0; k < len; k++) pkt.push_back(DATA_W'($urandom));
  endtask

  task automatic send_pkt(input bit hold);
    int i = 0, t = 0, len = pkt.size(), n_out;
    bit acc;
    n_out = (len <= DEPTH) ? len : DROP ? 0 : DEPTH;
    for (int k = 0; k < n_out; k++) begin
      exp_d.push_back(pkt[k]);
      exp_l.push_back(k == n_out - 1);
    end
    if (len > DEPTH) ovf_exp++;
    while (i < len && t < 400) begin
      i_tdata_valid = hold || ($urandom_range(0, 3) != 0);
      i_tdata = pkt[i];
      i_tdata_last = (i == len - 1);
      @(negedge i_clk);
      acc = i_tdata_valid && o_tready;
      @(posedge i_clk);
      #1;
      if (acc) i++;
      t++;
    end
    if (i < len) fail("send_timeout");
    if (!hold) i_tdata_valid = 1'b0;
    @(negedge i_clk);
    chk("first_valid_latency", 32'(o_data_valid), 32'(n_out != 0));
    if (DROP && len > DEPTH) chk("drop_idle_busy", 32'(o_busy), 0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_d.size() != 0 || o_tready !== 1'b1) && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 500) fail("drain_timeout");
    chk("overflow_count", ovf_seen, ovf_exp);
    chk("empty_after_packet", 32'(o_empty), 1);
    chk("count_after_packet", 32'(o_count), 0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_tready", 32'(o_tready), 0);
    chk("rst_valid", 32'(o_data_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_empty", 32'(o_empty), 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    n = 0;
    while (o_tready !== 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("tready_after_reset", 32'(o_tready), 1);
    i_tdata_valid = 1'b1;
    i_tdata_last = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_tdata_valid = 1'b0;
    @(negedge i_clk);
    chk("midload_count", 32'(o_count), 3);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_tready", 32'(o_tready), 0);
    chk("arst_valid", 32'(o_data_valid), 0);
    chk("arst_last", 32'(o_data_last), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_empty", 32'(o_empty), 1);
    chk("arst_count", 32'(o_count), 0);
    chk("arst_overflow", 32'(o_overflow), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    ready_mode = 0;
    pkt = '{8'h11, 8'h22, 8'h33};
    send_pkt(1'b0);
    wait_idle();
    ready_mode = 1;
    pkt = '{8'h11, 8'h22, 8'h33};
    send_pkt(1'b0);
    wait_idle();
    ready_mode = 2;
    max_cnt = 0;
    fill(DEPTH);
    send_pkt(1'b0);
    wait_idle();
    chk("full_packet_max_count", max_cnt, DEPTH);
    fill(DEPTH + 4);
    send_pkt(1'b0);
    wait_idle();
    for (int p = 0; p < 12; p++) begin
      ready_mode = $urandom_range(0, 2);
      fill($urandom_range(1, DEPTH + 5));
      send_pkt(1'b0);
      wait_idle();
    end
    ready_mode = 2;
    for (int p = 0; p < 3; p++) begin
      fill($urandom_range(1, DEPTH));
      send_pkt(1'b1);
    end
    i_tdata_valid = 1'b0;
    wait_idle();
    chk("max_count_bound", 32'(max_cnt <= DEPTH), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    fail("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
